prog_loader: RTL

- Sequential instruction encoder and loader that sits in front of the instruction memory write port.
- Accepts symbolic instructions (opcode enum plus operand field) over a valid/ready handshake.
- Packs each one into the 9-bit machine word that the control decoder expects, and writes the words to consecutive instruction-memory addresses starting from a programmed base.
- Used by the testbench/boot path to load programs; it reports completion and encoding errors.

---
 rtl/isa_pkg.sv | 90 +++++++++
 rtl/instr_pack.sv | 53 +++++
 rtl/prog_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode enum, 9-bit opcode prefixes, operand widths.
// Pure declarations; no logic, no latency.
// Shared with the control decoder so encoder and decoder cannot drift apart.
package isa_pkg;

    // Symbolic opcodes in their canonical order; values 21..31 are illegal.
    typedef enum logic [4:0] {
        OP_CMP  = 5'd0,
        OP_MOV  = 5'd1,
        OP_ADD  = 5'd2,
        OP_SUB  = 5'd3,
        OP_LSLR = 5'd4,
        OP_ROLR = 5'd5,
        OP_AND  = 5'd6,
        OP_OR   = 5'd7,
        OP_XOR  = 5'd8,
        OP_JGE  = 5'd9,
        OP_JG   = 5'd10,
        OP_JMP  = 5'd11,
        OP_INC  = 5'd12,
        OP_LSL  = 5'd13,
        OP_ROL  = 5'd14,
        OP_CLR  = 5'd15,
        OP_NOT  = 5'd16,
        OP_LDR  = 5'd17,
        OP_STR  = 5'd18,
        OP_LDR2 = 5'd19,
        OP_STR2 = 5'd20
    } op_e;

    // Machine word formats: A = 3-bit opcode, B = 5-bit, C = 6-bit.
    typedef enum logic [1:0] {
        FMT_A = 2'd0,
        FMT_B = 2'd1,
        FMT_C = 2'd2
    } fmt_e;

    localparam int unsigned WORD_W   = 9;
    localparam int unsigned OPND_W   = 6;
    localparam int unsigned OPND_W_A = 6;
    localparam int unsigned OPND_W_B = 4;
    localparam int unsigned OPND_W_C = 3;

    // Opcode prefixes already placed in the top bits of the 9-bit word.
    localparam logic [8:0] PFX_CMP  = 9'b000_000000;
    localparam logic [8:0] PFX_MOV  = 9'b001_000000;
    localparam logic [8:0] PFX_ADD  = 9'b01000_0000;
    localparam logic [8:0] PFX_SUB  = 9'b01001_0000;
    localparam logic [8:0] PFX_LSLR = 9'b01010_0000;
    localparam logic [8:0] PFX_ROLR = 9'b01011_0000;
    localparam logic [8:0] PFX_AND  = 9'b01100_0000;
    localparam logic [8:0] PFX_OR   = 9'b01101_0000;
    localparam logic [8:0] PFX_XOR  = 9'b01110_0000;
    localparam logic [8:0] PFX_JGE  = 9'b10000_0000;
    localparam logic [8:0] PFX_JG   = 9'b10001_0000;
    localparam logic [8:0] PFX_JMP  = 9'b10010_0000;
    localparam logic [8:0] PFX_INC  = 9'b101000_000;
    localparam logic [8:0] PFX_LSL  = 9'b101001_000;
    localparam logic [8:0] PFX_ROL  = 9'b101010_000;
    localparam logic [8:0] PFX_CLR  = 9'b101011_000;
    localparam logic [8:0] PFX_NOT  = 9'b101100_000;
    localparam logic [8:0] PFX_LDR  = 9'b101101_000;
    localparam logic [8:0] PFX_STR  = 9'b101110_000;
    localparam logic [8:0] PFX_LDR2 = 9'b110000_000;
    localparam logic [8:0] PFX_STR2 = 9'b110001_000;

    // Loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ERR  = 2'd2
    } ld_state_e;

    // Error codes reported on err_code.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;

    // Mask of the operand bits a format can carry.
    function automatic logic [OPND_W-1:0] opnd_mask(input fmt_e fmt);
        logic [OPND_W:0] one;
        one = (OPND_W+1)'(1);
        case (fmt)
            FMT_A:   opnd_mask = OPND_W'((one << OPND_W_A) - one);
            FMT_B:   opnd_mask = OPND_W'((one << OPND_W_B) - one);
            default: opnd_mask = OPND_W'((one << OPND_W_C) - one);
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Encodes a symbolic opcode + operand into the 9-bit machine word.
// Purely combinational, zero latency.
// No handshake; flags illegal opcodes and operands too wide for the format.
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0] op_i,
    input  logic [5:0] operand_i,
    output logic [8:0] word_o,
    output logic       illegal_o,
    output logic       overflow_o
);

    logic [8:0] prefix;
    fmt_e       fmt;
    logic [5:0] mask;

    // Opcode lookup: prefix bits and word format; anything unlisted is illegal.
    always_comb begin
        prefix    = '0;
        fmt       = FMT_A;
        illegal_o = 1'b0;
        case (op_i)
            OP_CMP:  begin prefix = PFX_CMP;  fmt = FMT_A; end
            OP_MOV:  begin prefix = PFX_MOV;  fmt = FMT_A; end
            OP_ADD:  begin prefix = PFX_ADD;  fmt = FMT_B; end
            OP_SUB:  begin prefix = PFX_SUB;  fmt = FMT_B; end
            OP_LSLR: begin prefix = PFX_LSLR; fmt = FMT_B; end
            OP_ROLR: begin prefix = PFX_ROLR; fmt = FMT_B; end
            OP_AND:  begin prefix = PFX_AND;  fmt = FMT_B; end
            OP_OR:   begin prefix = PFX_OR;   fmt = FMT_B; end
            OP_XOR:  begin prefix = PFX_XOR;  fmt = FMT_B; end
            OP_JGE:  begin prefix = PFX_JGE;  fmt = FMT_B; end
            OP_JG:   begin prefix = PFX_JG;   fmt = FMT_B; end
            OP_JMP:  begin prefix = PFX_JMP;  fmt = FMT_B; end
            OP_INC:  begin prefix = PFX_INC;  fmt = FMT_C; end
            OP_LSL:  begin prefix = PFX_LSL;  fmt = FMT_C; end
            OP_ROL:  begin prefix = PFX_ROL;  fmt = FMT_C; end
            OP_CLR:  begin prefix = PFX_CLR;  fmt = FMT_C; end
            OP_NOT:  begin prefix = PFX_NOT;  fmt = FMT_C; end
            OP_LDR:  begin prefix = PFX_LDR;  fmt = FMT_C; end
            OP_STR:  begin prefix = PFX_STR;  fmt = FMT_C; end
            OP_LDR2: begin prefix = PFX_LDR2; fmt = FMT_C; end
            OP_STR2: begin prefix = PFX_STR2; fmt = FMT_C; end
            default: illegal_o = 1'b1;
        endcase
    end

    assign mask       = opnd_mask(fmt);
    assign word_o     = prefix | {3'b000, operand_i & mask};
    assign overflow_o = |(operand_i & ~mask);

endmodule

// File: rtl/prog_loader.sv
// Loads encoded instructions into consecutive imem addresses from a base.
// Latency: accepted word appears on the imem write port the next cycle.
// in_ready only in LOAD; one word per cycle at full rate, no internal buffering.
module prog_loader
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [4:0]        in_op,
    input  logic [5:0]        in_operand,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [8:0]        imem_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [8:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [8:0] pk_word;
    logic       pk_illegal;
    logic       pk_overflow;
    logic       accept;

    instr_pack u_pack (
        .op_i       (in_op),
        .operand_i  (in_operand),
        .word_o     (pk_word),
        .illegal_o  (pk_illegal),
        .overflow_o (pk_overflow)
    );

    assign accept = in_valid && (state_q == ST_LOAD);

    // Next-state logic: abort dominates everything, including start and a pending write.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_code_d = err_code_q;

        if (abort) begin
            state_d    = ST_IDLE;
            err_code_d = ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        err_code_d = ERR_NONE;
                        addr_d     = base_addr;
                        remain_d   = length;
                        if (length == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (pk_illegal) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_ILLEGAL;
                        end else if (pk_overflow) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_OVF;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = pk_word;
                            addr_d    = addr_q + ADDR_W'(1);
                            remain_d  = remain_q - LEN_W'(1);
                            if (remain_q == LEN_W'(1)) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    err_code_d = ERR_NONE;
                end
            endcase
        end
    end

    // State and registered write-port outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_code_q <= err_code_d;
        end
    end

    assign in_ready     = (state_q == ST_LOAD);
    assign busy         = (state_q == ST_LOAD);
    assign err          = (state_q == ST_ERR);
    assign err_code     = err_code_q;
    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign done         = done_q;

endmodule
